// File: rtl/act_sched_pkg.sv
// Shared definitions for the activation-engine scheduler: FSM state
// encoding and the width helpers used to size index and counter registers.
package act_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Bits needed to index n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count from 0 up to and including t.
  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/act_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the priority pointer, scanning cyclically. The wrap is computed
// explicitly so NUM_REQ need not be a power of two.
module rr_arbiter
  import act_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_any_req,
  output logic [IDX_W-1:0]   o_winner,
  output logic [NUM_REQ-1:0] o_onehot
);

  logic [IDX_W-1:0] w_cand [NUM_REQ];

  // Candidate k is the requester k positions after the pointer, wrapped.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
    assign w_cand[k] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                       IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
  end

  // First active candidate in cyclic order wins.
  always_comb begin
    o_any_req = 1'b0;
    o_winner  = '0;
    o_onehot  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any_req && i_req[w_cand[k]]) begin
        o_any_req = 1'b1;
        o_winner  = w_cand[k];
      end
    end
    o_onehot[o_winner] = o_any_req;
  end

endmodule

// File: rtl/act_scheduler.sv
// Shares one element-serial activation engine between NUM_REQ requesters.
// Round-robin grant, operand capture at grant, result return with a
// one-cycle response pulse, and a watchdog that aborts and resets a hung
// engine. Every output comes straight from a register.
module act_scheduler
  import act_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 128,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 512
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*WIDTH*DATA_WIDTH-1:0]   req_vector,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic                                  resp_error,
  output logic [WIDTH*DATA_WIDTH-1:0]           resp_vector,
  output logic                                  busy,
  output logic                                  eng_enable,
  output logic                                  eng_reset,
  output logic [WIDTH*DATA_WIDTH-1:0]           eng_input_vector,
  input  logic [WIDTH*DATA_WIDTH-1:0]           eng_output_vector,
  input  logic                                  eng_done
);

  localparam int VW    = WIDTH * DATA_WIDTH;
  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic               r_resp_error, w_resp_error_nxt;
  logic [VW-1:0]      r_resp_vector, w_resp_vector_nxt;
  logic [VW-1:0]      r_in_vec, w_in_vec_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_enable, w_enable_nxt;
  logic               r_eng_reset, w_eng_reset_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_run_cnt, w_run_cnt_nxt;

  logic               w_any_req;
  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic [VW-1:0]      w_sel_vec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_any_req (w_any_req),
    .o_winner  (w_winner),
    .o_onehot  (w_onehot)
  );

  // Select the winner's operand slice from the flattened request bus.
  always_comb begin
    w_sel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) w_sel_vec = req_vector[i*VW +: VW];
    end
  end

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_resp_valid_nxt  = '0;
    w_resp_error_nxt  = 1'b0;
    w_resp_vector_nxt = r_resp_vector;
    w_in_vec_nxt      = r_in_vec;
    w_enable_nxt      = r_enable;
    w_eng_reset_nxt   = 1'b0;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_run_cnt_nxt     = r_run_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_in_vec_nxt  = w_sel_vec;
          w_grant_nxt   = w_onehot;
          w_enable_nxt  = 1'b1;
          w_run_cnt_nxt = '0;
          w_rr_ptr_nxt  = (w_winner == IDX_W'(NUM_REQ-1)) ? '0 : w_winner + IDX_W'(1);
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
        w_run_cnt_nxt = r_run_cnt + CNT_W'(1);
        // A done seen with run_cnt==0 may be left over from the last job.
        if ((r_run_cnt != '0) && eng_done) begin
          w_resp_vector_nxt = eng_output_vector;
          w_enable_nxt      = 1'b0;
          w_resp_valid_nxt  = r_grant;
          w_state_nxt       = RESP;
        end else if (r_run_cnt == CNT_W'(TIMEOUT-1)) begin
          w_resp_vector_nxt = '0;
          w_enable_nxt      = 1'b0;
          w_eng_reset_nxt   = 1'b1;
          w_resp_valid_nxt  = r_grant;
          w_resp_error_nxt  = 1'b1;
          w_state_nxt       = ABORT;
        end
      end
      RESP: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
      ABORT: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt  = '0;
        w_enable_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset holds the engine in reset too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_resp_valid  <= '0;
      r_resp_error  <= 1'b0;
      r_resp_vector <= '0;
      r_in_vec      <= '0;
      r_busy        <= 1'b0;
      r_enable      <= 1'b0;
      r_eng_reset   <= 1'b1;
      r_rr_ptr      <= '0;
      r_run_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_error  <= w_resp_error_nxt;
      r_resp_vector <= w_resp_vector_nxt;
      r_in_vec      <= w_in_vec_nxt;
      r_busy        <= w_busy_nxt;
      r_enable      <= w_enable_nxt;
      r_eng_reset   <= w_eng_reset_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_run_cnt     <= w_run_cnt_nxt;
    end
  end

  assign grant            = r_grant;
  assign resp_valid       = r_resp_valid;
  assign resp_error       = r_resp_error;
  assign resp_vector      = r_resp_vector;
  assign busy             = r_busy;
  assign eng_enable       = r_enable;
  assign eng_reset        = r_eng_reset;
  assign eng_input_vector = r_in_vec;

endmodule
